// File: rtl/nco_ctrl_pkg.sv
// Shared types and default sizes for the NCO frequency-sweep controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nco_ctrl_pkg;

    localparam int PHI_W_DEF   = 32;  // NCO phase-increment width
    localparam int DATA_W_DEF  = 13;  // NCO sine sample width
    localparam int CNT_W_DEF   = 16;  // step / dwell counter width
    localparam int FLUSH_N_DEF = 8;   // settling samples dropped after each retune

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

endpackage : nco_ctrl_pkg

// File: rtl/nco_sweep_ctrl.sv
// Steps the NCO phase increment through start + k*step, drops FLUSH_N settling
// samples per frequency, then forwards dwell samples tagged with the step index.
// Latency: nco_valid_i -> smp_valid_o one cycle; start -> busy/phi one cycle.
// Backpressure: none downstream; gaps in nco_valid_i simply stall the counters.
//
// Ports:
//   clk, reset                 single clock, asynchronous active-high reset
//   start, abort               sweep request (IDLE only) / unconditional stop
//   phi_start_i, phi_step_i    first phase increment and per-step increment
//   num_steps_i, dwell_i       frequencies per sweep, samples per frequency (0 -> 1)
//   nco_valid_i, nco_sin_i     NCO sample stream in
//   phi_inc_o, nco_clken_o     NCO controls
//   busy_o, done_o, step_idx_o status
//   smp_valid_o/data_o/last_o  forwarded sample stream
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int PHI_W   = PHI_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int FLUSH_N = FLUSH_N_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [PHI_W-1:0]  phi_start_i,
    input  logic [PHI_W-1:0]  phi_step_i,
    input  logic [CNT_W-1:0]  num_steps_i,
    input  logic [CNT_W-1:0]  dwell_i,
    input  logic              nco_valid_i,
    input  logic [DATA_W-1:0] nco_sin_i,
    output logic [PHI_W-1:0]  phi_inc_o,
    output logic              nco_clken_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  step_idx_o,
    output logic              smp_valid_o,
    output logic [DATA_W-1:0] smp_data_o,
    output logic              smp_last_o
);

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_N - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    sweep_state_e      state_q;
    logic [PHI_W-1:0]  phi_q;
    logic [PHI_W-1:0]  cfg_phi_step_q;
    logic [CNT_W-1:0]  cfg_steps_q;
    logic [CNT_W-1:0]  cfg_dwell_q;
    logic [CNT_W-1:0]  step_q;
    logic [CNT_W-1:0]  flush_q;
    logic [CNT_W-1:0]  dwell_cnt_q;
    logic              retune_q;
    logic              busy_q;
    logic              done_q;
    logic              smp_valid_q;
    logic [DATA_W-1:0] smp_data_q;
    logic              smp_last_q;

    // Single phase adder; wraps modulo 2^PHI_W.
    logic [PHI_W-1:0]  phi_next_d;
    assign phi_next_d = phi_q + cfg_phi_step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            phi_q          <= '0;
            cfg_phi_step_q <= '0;
            cfg_steps_q    <= ONE;
            cfg_dwell_q    <= ONE;
            step_q         <= '0;
            flush_q        <= '0;
            dwell_cnt_q    <= '0;
            retune_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            smp_valid_q    <= 1'b0;
            smp_data_q     <= '0;
            smp_last_q     <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_last_q  <= 1'b0;

            if (abort) begin
                // Abort beats everything, including a sample arriving this cycle.
                state_q  <= ST_IDLE;
                busy_q   <= 1'b0;
                retune_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // busy stays up through the done cycle and drops here.
                        busy_q <= 1'b0;
                        if (start) begin
                            cfg_phi_step_q <= phi_step_i;
                            cfg_steps_q    <= (num_steps_i == '0) ? ONE : num_steps_i;
                            cfg_dwell_q    <= (dwell_i == '0) ? ONE : dwell_i;
                            phi_q          <= phi_start_i;
                            step_q         <= '0;
                            flush_q        <= '0;
                            retune_q       <= 1'b0;
                            busy_q         <= 1'b1;
                            state_q        <= ST_SETTLE;
                        end
                    end

                    ST_SETTLE: begin
                        // Retune is applied one cycle after the step's last sample
                        // so every forwarded sample carries its own step's tag.
                        if (retune_q) begin
                            phi_q    <= phi_next_d;
                            step_q   <= step_q + ONE;
                            retune_q <= 1'b0;
                        end
                        if (nco_valid_i) begin
                            if (flush_q == FLUSH_LAST) begin
                                dwell_cnt_q <= '0;
                                state_q     <= ST_DWELL;
                            end else begin
                                flush_q <= flush_q + ONE;
                            end
                        end
                    end

                    ST_DWELL: begin
                        if (nco_valid_i) begin
                            smp_valid_q <= 1'b1;
                            smp_data_q  <= nco_sin_i;
                            if (dwell_cnt_q == cfg_dwell_q - ONE) begin
                                smp_last_q <= 1'b1;
                                if (step_q == cfg_steps_q - ONE) begin
                                    state_q <= ST_DONE;
                                end else begin
                                    retune_q <= 1'b1;
                                    flush_q  <= '0;
                                    state_q  <= ST_SETTLE;
                                end
                            end else begin
                                dwell_cnt_q <= dwell_cnt_q + ONE;
                            end
                        end
                    end

                    ST_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign phi_inc_o   = phi_q;
    assign nco_clken_o = busy_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign step_idx_o  = step_q;
    assign smp_valid_o = smp_valid_q;
    assign smp_data_o  = smp_data_q;
    assign smp_last_o  = smp_last_q;

endmodule : nco_sweep_ctrl

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sequencer for the 1 MHz-class NCO. It steps the NCO phase increment through a programmed list of frequencies: start, step and count. At each frequency it discards NCO settling samples, then forwards a fixed number of valid sine samples downstream, tagged with a step index. It sits between the host/config registers and the NCO core and owns the NCO's `phi_inc_i` and `clken` inputs.

## Interface
- `PHI_W`, 32, phase-increment width (matches NCO `phi_inc_i`)
- `DATA_W`, 13, NCO sine sample width (two's complement)
- `CNT_W`, 16, width of step/dwell counters
- `FLUSH_N`, 8, NCO-valid samples discarded after each retune (>=1)

Ports:
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle request; honoured only in IDLE
- `abort` in 1: terminate sweep; wins over every other event
- `phi_start_i` in PHI_W: first phase increment
- `phi_step_i` in PHI_W: increment added per step, modulo 2^PHI_W
- `num_steps_i` in CNT_W: frequencies in sweep; 0 treated as 1
- `dwell_i` in CNT_W: samples forwarded per frequency; 0 treated as 1
- `nco_valid_i` in 1: NCO `out_valid`
- `nco_sin_i` in DATA_W: NCO `fsin_o`
- `phi_inc_o` out PHI_W: drives NCO `phi_inc_i`
- `nco_clken_o` out 1: drives NCO `clken`
- `busy_o` out 1: high outside IDLE
- `done_o` out 1: one-cycle pulse on normal completion
- `step_idx_o` out CNT_W: index of current frequency
- `smp_valid_o`, `smp_data_o` (DATA_W), `smp_last_o` out: forwarded sample stream; last marks final sample of a step

## Operation
- States: IDLE, SETTLE, DWELL, DONE.
- IDLE: `start`=1 and `abort`=0 -> latch config (zero-substituted counts), `phi_inc_o<=phi_start_i`, `step_idx_o<=0`, flush count<=0, go to SETTLE.
- SETTLE: each `nco_valid_i` increments the flush count; samples are not forwarded. On the FLUSH_N-th valid -> DWELL with dwell count<=0.
- DWELL: each `nco_valid_i` forwards `nco_sin_i` and increments the dwell count. On the valid where count==dwell-1, assert `smp_last_o`, then:
  - if `step_idx_o`==num_steps-1 -> DONE;
  - else `phi_inc_o<=phi_inc_o+phi_step_i` (wraps), `step_idx_o++`, -> SETTLE.
- DONE: `done_o`=1 for this cycle, -> IDLE.
- `abort`=1 in any state -> IDLE next cycle. No `done_o`. Any sample in that cycle is not forwarded.
- `start` outside IDLE is ignored. Config inputs are sampled only at accepted start.
- `nco_clken_o` = `busy_o` (registered with state). `phi_inc_o` holds its last value in IDLE.

## Timing
- Reset values: state IDLE; `phi_inc_o`=0, `nco_clken_o`=0, `busy_o`=0, `done_o`=0, `step_idx_o`=0, `smp_valid_o`=0, `smp_data_o`=0, `smp_last_o`=0.
- `start` -> `busy_o`/`nco_clken_o` high, and `phi_inc_o` updated, 1 cycle later.
- Sample forward latency: `nco_valid_i` at cycle t -> `smp_valid_o` at t+1, with data registered unchanged.
- Retune: `phi_inc_o` changes in the cycle after the last sample's `smp_valid_o` is registered. The flush count starts from the next `nco_valid_i`.
- `done_o` is asserted 1 cycle after the final `smp_last_o`. `busy_o` falls the cycle after `done_o`.
- Gaps in `nco_valid_i` stall counting with no timeout. All outputs are registered.

## Structure
- Package `nco_ctrl_pkg`: state enum (IDLE, SETTLE, DWELL, DONE), defaults for PHI_W/DATA_W/CNT_W/FLUSH_N.
- Single module. No sub-module needed; counters are inline. Phase accumulator add is one PHI_W adder.

## Test plan
- Basic sweep: `phi_start`=0x0041_8937, `phi_step`=0x0010_0000, `num_steps`=3, `dwell`=4, FLUSH_N=8, NCO valid every cycle.
  - Expect 12 `smp_valid_o` and `step_idx_o` 0,1,2.
  - Expect `phi_inc_o` values 0x0041_8937, 0x0051_8937, 0x0061_8937.
  - Expect `smp_last_o` on samples 4, 8 and 12, and one `done_o`.
- Zero counts: `num_steps`=0, `dwell`=0 -> exactly one step and one forwarded sample (`smp_last_o`=1), then `done_o`.
- Wrap: `phi_start`=0xFFFF_FFF0, `phi_step`=0x20, 2 steps -> second `phi_inc_o`=0x0000_0010.
- Abort mid-DWELL on the 2nd sample of step 1 -> no further `smp_valid_o`, no `done_o`, `busy_o`=0 next cycle, `nco_clken_o`=0.
- `start` while busy, and `start`+`abort` together in IDLE -> both ignored; config and `step_idx_o` unchanged.
- Reset asserted mid-SETTLE -> all outputs at reset values immediately (asynchronously); a fresh `start` after release runs a full sweep.
